// File: rtl/w2r_sync_status_if.sv
// Read-domain FIFO status bus: synchronized write pointer in, read pointer, address and status out.
interface w2r_sync_status_if #(
    parameter int ADDRSIZE = 4
);
    logic [ADDRSIZE:0]   wptr_gray;
    logic                r_inc;
    logic [ADDRSIZE:0]   ae_thresh;
    logic                err_clr;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr_gray;
    logic                r_empty;
    logic                r_almost_empty;
    logic [ADDRSIZE:0]   r_count;
    logic                sync_err;

    modport master (
        output wptr_gray, r_inc, ae_thresh, err_clr,
        input  raddr, rptr_gray, r_empty, r_almost_empty, r_count, sync_err
    );

    modport slave (
        input  wptr_gray, r_inc, ae_thresh, err_clr,
        output raddr, rptr_gray, r_empty, r_almost_empty, r_count, sync_err
    );
endinterface

// File: rtl/w2r_sync_status.sv
// Read-domain half of an async FIFO: write-pointer synchronizer, read pointer,
// registered empty / almost-empty / fill count, and a sticky pointer-CDC error flag.
module w2r_sync_status #(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             r_clk,
    input  logic             r_rst_n,
    w2r_sync_status_if.slave bus
);
    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("w2r_sync_status: SYNC_STAGES must be 2 or more");
    end

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic int unsigned popcount(input logic [PW-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < PW; i++) n += int'(v[i]);
        return n;
    endfunction

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] sync_d [SYNC_STAGES];
    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic [PW-1:0] count_q, count_d;
    logic [PW-1:0] s_prev_q, s_prev_d;
    logic          empty_q, empty_d;
    logic          aempty_q, aempty_d;
    logic          err_q, err_d;
    logic [PW-1:0] s_wgray, s_wbin;
    logic          rd_acc, viol;

    // Synchronizer boundary: pure flop chain, nothing between stages.
    always_comb begin
        sync_d[0] = bus.wptr_gray;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    assign s_wgray = sync_q[SYNC_STAGES-1];
    assign s_wbin  = gray2bin(s_wgray);

    // Status boundary: everything below is computed from the synchronized pointer.
    always_comb begin
        rd_acc   = bus.r_inc & ~empty_q;
        rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, rd_acc};
        rgray_d  = bin2gray(rbin_d);
        count_d  = s_wbin - rbin_d;
        empty_d  = (rgray_d == s_wgray);
        aempty_d = (count_d <= bus.ae_thresh);
        s_prev_d = s_wgray;
        viol     = (popcount(s_wgray ^ s_prev_q) > 1) || (count_d > DEPTH);
        err_d    = viol | (err_q & ~bus.err_clr);
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            rbin_q   <= '0;
            rgray_q  <= '0;
            count_q  <= '0;
            s_prev_q <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            count_q  <= count_d;
            s_prev_q <= s_prev_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            err_q    <= err_d;
        end
    end

    assign bus.raddr          = rbin_q[ADDRSIZE-1:0];
    assign bus.rptr_gray      = rgray_q;
    assign bus.r_empty        = empty_q;
    assign bus.r_almost_empty = aempty_q;
    assign bus.r_count        = count_q;
    assign bus.sync_err       = err_q;
endmodule

// File: tb/tb_w2r_sync_status.sv
// Scoreboard bench for w2r_sync_status: reset, latency, fill/drain, wrap, CDC error, async reset.
module tb_w2r_sync_status;
    localparam int AW = 4;
    localparam int PW = AW + 1;

    logic r_clk = 1'b0;
    logic r_rst_n;
    always #5 r_clk = ~r_clk;

    w2r_sync_status_if #(.ADDRSIZE(AW)) bus ();
    w2r_sync_status_if #(.ADDRSIZE(AW)) bus3 ();

    w2r_sync_status #(.ADDRSIZE(AW), .SYNC_STAGES(2)) dut (
        .r_clk(r_clk), .r_rst_n(r_rst_n), .bus(bus)
    );
    w2r_sync_status #(.ADDRSIZE(AW), .SYNC_STAGES(3)) dut3 (
        .r_clk(r_clk), .r_rst_n(r_rst_n), .bus(bus3)
    );

    typedef struct packed {
        logic [PW-1:0] cnt;
        logic          emp;
        logic          ae;
        logic [AW-1:0] ra;
        logic [PW-1:0] rg;
        logic          err;
    } st_t;

    typedef struct {
        string nm;
        st_t   v;
    } item_t;

    item_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [PW-1:0] g(input int b);
        logic [PW-1:0] x;
        x = PW'(b);
        return x ^ (x >> 1);
    endfunction

    function automatic st_t mk(input int rb, input int cnt, input bit emp, input bit ae, input bit err);
        st_t s;
        logic [PW-1:0] r;
        r     = PW'(rb);
        s.cnt = PW'(cnt);
        s.emp = emp;
        s.ae  = ae;
        s.ra  = r[AW-1:0];
        s.rg  = g(rb);
        s.err = err;
        return s;
    endfunction

    function automatic item_t mkit(input string n, input st_t v);
        item_t it;
        it.nm = n;
        it.v  = v;
        return it;
    endfunction

    function automatic st_t cur();
        st_t s;
        s.cnt = bus.r_count;
        s.emp = bus.r_empty;
        s.ae  = bus.r_almost_empty;
        s.ra  = bus.raddr;
        s.rg  = bus.rptr_gray;
        s.err = bus.sync_err;
        return s;
    endfunction

    function automatic string fmt(input st_t s);
        return $sformatf("cnt=%0d emp=%b ae=%b raddr=%0d rgray=%b err=%b",
                         s.cnt, s.emp, s.ae, s.ra, s.rg, s.err);
    endfunction

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic do_reset();
        r_rst_n = 1'b0;
        bus.wptr_gray  = '0;
        bus.r_inc      = 1'b0;
        bus.err_clr    = 1'b0;
        bus3.wptr_gray = '0;
        tick();
        r_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        item_t it;
        st_t got;
        r_rst_n = 1'b0;
        bus.ae_thresh = PW'(2);
        for (int i = 0; i < 4; i++) begin
            bus.wptr_gray = PW'($urandom);
            bus.r_inc     = i[0];
            bus.err_clr   = ~i[0];
            sb.push_back(mkit("reset_hold", mk(0, 0, 1'b1, 1'b1, 1'b0)));
            tick();
            it = sb.pop_front(); got = cur(); checks++;
            if (got !== it.v) begin errors++; $display("FAIL %s got %s exp %s", it.nm, fmt(got), fmt(it.v)); end
        end
        bus.wptr_gray = '0;
        bus.r_inc     = 1'b0;
        bus.err_clr   = 1'b0;
        r_rst_n       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mkit("reset_idle", mk(0, 0, 1'b1, 1'b1, 1'b0)));
            tick();
            it = sb.pop_front(); got = cur(); checks++;
            if (got !== it.v) begin errors++; $display("FAIL %s got %s exp %s", it.nm, fmt(got), fmt(it.v)); end
        end
    endtask

    task automatic test_latency();
        item_t it;
        st_t got;
        do_reset();
        bus.ae_thresh  = '0;
        bus.wptr_gray  = 5'b00001;
        bus3.wptr_gray = 5'b00001;
        for (int e = 1; e <= 4; e++) begin
            if (e >= 3) sb.push_back(mkit("latency_ss2", mk(0, 1, 1'b0, 1'b0, 1'b0)));
            else        sb.push_back(mkit("latency_ss2", mk(0, 0, 1'b1, 1'b1, 1'b0)));
            tick();
            it = sb.pop_front(); got = cur(); checks++;
            if (got !== it.v) begin errors++; $display("FAIL %s edge %0d got %s exp %s", it.nm, e, fmt(got), fmt(it.v)); end
            checks++;
            if (bus3.r_empty !== (e < 4)) begin
                errors++; $display("FAIL latency_ss3_empty edge %0d got %b exp %b", e, bus3.r_empty, (e < 4));
            end
            checks++;
            if (bus3.r_count !== PW'(e >= 4)) begin
                errors++; $display("FAIL latency_ss3_count edge %0d got %0d exp %0d", e, bus3.r_count, (e >= 4));
            end
        end
    endtask

    task automatic test_fill_drain();
        item_t it;
        st_t got;
        int rb, cnt;
        do_reset();
        bus.ae_thresh = PW'(2);
        for (int k = 1; k <= 5; k++) begin
            bus.wptr_gray = g(k);
            tick();
        end
        repeat (3) tick();
        sb.push_back(mkit("fill_level", mk(0, 5, 1'b0, 1'b0, 1'b0)));
        tick();
        it = sb.pop_front(); got = cur(); checks++;
        if (got !== it.v) begin errors++; $display("FAIL %s got %s exp %s", it.nm, fmt(got), fmt(it.v)); end
        bus.r_inc = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            rb  = (n <= 5) ? n : 5;
            cnt = 5 - rb;
            sb.push_back(mkit((n <= 5) ? "drain_pop" : "drain_empty_inc",
                              mk(rb, cnt, (cnt == 0), (cnt <= 2), 1'b0)));
            tick();
            it = sb.pop_front(); got = cur(); checks++;
            if (got !== it.v) begin errors++; $display("FAIL %s n=%0d got %s exp %s", it.nm, n, fmt(got), fmt(it.v)); end
        end
        bus.r_inc = 1'b0;
    endtask

    task automatic test_wrap();
        item_t it;
        st_t got;
        logic [AW-1:0] pra;
        logic [PW-1:0] prg;
        bit saw_ra, saw_rg;
        do_reset();
        bus.ae_thresh = PW'(2);
        pra = '0; prg = '0; saw_ra = 1'b0; saw_rg = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c < 32) bus.wptr_gray = g((c + 1) % 32);
            bus.r_inc = (c >= 8);
            tick();
            checks++;
            if (bus.r_count > PW'(16)) begin errors++; $display("FAIL wrap_count_bound cycle %0d got %0d exp <=16", c, bus.r_count); end
            checks++;
            if (bus.sync_err !== 1'b0) begin errors++; $display("FAIL wrap_sync_err cycle %0d got %b exp 0", c, bus.sync_err); end
            if (pra == 4'd15 && bus.raddr == 4'd0) saw_ra = 1'b1;
            if (prg == 5'b10000 && bus.rptr_gray == 5'b00000) saw_rg = 1'b1;
            pra = bus.raddr;
            prg = bus.rptr_gray;
        end
        bus.r_inc = 1'b0;
        checks++;
        if (saw_ra !== 1'b1) begin errors++; $display("FAIL wrap_raddr_15_to_0 got %b exp 1", saw_ra); end
        checks++;
        if (saw_rg !== 1'b1) begin errors++; $display("FAIL wrap_rgray_10000_to_0 got %b exp 1", saw_rg); end
        sb.push_back(mkit("wrap_end", mk(0, 0, 1'b1, 1'b1, 1'b0)));
        tick();
        it = sb.pop_front(); got = cur(); checks++;
        if (got !== it.v) begin errors++; $display("FAIL %s got %s exp %s", it.nm, fmt(got), fmt(it.v)); end
    endtask

    task automatic test_cdc_error();
        item_t it;
        st_t got;
        do_reset();
        bus.ae_thresh = PW'(2);
        bus.wptr_gray = 5'b00011;
        for (int e = 1; e <= 5; e++) begin
            sb.push_back(mkit("cdc_set", mk(0, (e >= 3) ? 2 : 0, (e < 3), 1'b1, (e >= 3))));
            tick();
            it = sb.pop_front(); got = cur(); checks++;
            if (got !== it.v) begin errors++; $display("FAIL %s edge %0d got %s exp %s", it.nm, e, fmt(got), fmt(it.v)); end
        end
        bus.err_clr = 1'b1;
        sb.push_back(mkit("cdc_clear", mk(0, 2, 1'b0, 1'b1, 1'b0)));
        tick();
        bus.err_clr = 1'b0;
        it = sb.pop_front(); got = cur(); checks++;
        if (got !== it.v) begin errors++; $display("FAIL %s got %s exp %s", it.nm, fmt(got), fmt(it.v)); end
        sb.push_back(mkit("cdc_clear_hold", mk(0, 2, 1'b0, 1'b1, 1'b0)));
        tick();
        it = sb.pop_front(); got = cur(); checks++;
        if (got !== it.v) begin errors++; $display("FAIL %s got %s exp %s", it.nm, fmt(got), fmt(it.v)); end
        // Two-bit jump back to zero; clear is raised while the violation is live.
        bus.wptr_gray = 5'b00000;
        tick();
        tick();
        bus.err_clr = 1'b1;
        sb.push_back(mkit("cdc_set_wins", mk(0, 0, 1'b1, 1'b1, 1'b1)));
        tick();
        bus.err_clr = 1'b0;
        it = sb.pop_front(); got = cur(); checks++;
        if (got !== it.v) begin errors++; $display("FAIL %s got %s exp %s", it.nm, fmt(got), fmt(it.v)); end
        sb.push_back(mkit("cdc_sticky", mk(0, 0, 1'b1, 1'b1, 1'b1)));
        tick();
        it = sb.pop_front(); got = cur(); checks++;
        if (got !== it.v) begin errors++; $display("FAIL %s got %s exp %s", it.nm, fmt(got), fmt(it.v)); end
    endtask

    task automatic test_async_reset();
        item_t it;
        st_t got;
        do_reset();
        bus.ae_thresh = PW'(2);
        for (int k = 1; k <= 8; k++) begin
            bus.wptr_gray = g(k);
            tick();
        end
        repeat (3) tick();
        sb.push_back(mkit("ar_full", mk(0, 8, 1'b0, 1'b0, 1'b0)));
        tick();
        it = sb.pop_front(); got = cur(); checks++;
        if (got !== it.v) begin errors++; $display("FAIL %s got %s exp %s", it.nm, fmt(got), fmt(it.v)); end
        bus.r_inc = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            sb.push_back(mkit("ar_pop", mk(n, 8 - n, 1'b0, ((8 - n) <= 2), 1'b0)));
            tick();
            it = sb.pop_front(); got = cur(); checks++;
            if (got !== it.v) begin errors++; $display("FAIL %s n=%0d got %s exp %s", it.nm, n, fmt(got), fmt(it.v)); end
        end
        #2;
        r_rst_n = 1'b0;
        #1;
        sb.push_back(mkit("ar_async", mk(0, 0, 1'b1, 1'b1, 1'b0)));
        it = sb.pop_front(); got = cur(); checks++;
        if (got !== it.v) begin errors++; $display("FAIL %s got %s exp %s", it.nm, fmt(got), fmt(it.v)); end
        bus.wptr_gray = '0;
        tick();
        r_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mkit("ar_after", mk(0, 0, 1'b1, 1'b1, 1'b0)));
            tick();
            it = sb.pop_front(); got = cur(); checks++;
            if (got !== it.v) begin errors++; $display("FAIL %s got %s exp %s", it.nm, fmt(got), fmt(it.v)); end
        end
        bus.r_inc = 1'b0;
    endtask

    initial begin
        r_rst_n        = 1'b0;
        bus.wptr_gray  = '0;
        bus.r_inc      = 1'b0;
        bus.ae_thresh  = PW'(2);
        bus.err_clr    = 1'b0;
        bus3.wptr_gray = '0;
        bus3.r_inc     = 1'b0;
        bus3.ae_thresh = PW'(2);
        bus3.err_clr   = 1'b0;
        #1;
        test_reset();
        test_latency();
        test_fill_drain();
        test_wrap();
        test_cdc_error();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
